// File: rtl/tt_sel_pkg.sv
// Shared types and constants for the design-selection sequencer.
// State encoding, default dwell lengths and the NONE-address helper.
package tt_sel_pkg;

  localparam int DEF_ADDR_W        = 10;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_RST_CYCLES    = 4;

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    STOP_CLK   = 3'd1,
    ASSERT_RST = 3'd2,
    DISABLE    = 3'd3,
    RESET_HOLD = 3'd4,
    RUN        = 3'd5
  } sel_state_t;

  // All-ones address of the given width: no design selected.
  function automatic logic [31:0] none_addr(input int addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/tt_sel_sequencer_if.sv
// Request handshake plus the select/enable bundle toward the decoder and mux spine.
// master = chip controller side, slave = sequencer side.
interface tt_sel_sequencer_if
  import tt_sel_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] um_addr;
  logic              um_ena;
  logic              um_rst_n;
  logic              um_clk_en;
  logic              ui_pass;

  modport master (
    output req_valid, req_addr,
    input  req_ready, busy, done, um_addr, um_ena, um_rst_n, um_clk_en, ui_pass
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, busy, done, um_addr, um_ena, um_rst_n, um_clk_en, ui_pass
  );
endinterface

// File: rtl/tt_sel_dwell.sv
// Loadable down-counter timing the DISABLE and RESET_HOLD dwells.
// last_o flags the final cycle of a dwell (count of 1).
module tt_sel_dwell #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/tt_sel_sequencer.sv
// Moves the active-design selection in a safe order so that a design with ena low
// always sees clock stopped, reset asserted and inputs forced to zero.
module tt_sel_sequencer
  import tt_sel_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  tt_sel_sequencer_if.slave   sel
);
  localparam logic [ADDR_W-1:0] NONE_ADDR = ADDR_W'(none_addr(ADDR_W));
  localparam int DWELL_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);

  sel_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [ADDR_W-1:0] um_addr_q;
  logic              done_q;
  logic              busy;
  logic              accept;
  logic              dwell_load;
  logic [CNT_W-1:0]  dwell_val;
  logic              dwell_last;
  logic              ena, pass, clk_en, rst_n;

  assign busy   = (state_q != OFF) && (state_q != RUN);
  assign accept = sel.req_valid && !busy;

  tt_sel_dwell #(.CNT_W(CNT_W)) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .load_i    (dwell_load),
    .load_val_i(dwell_val),
    .last_o    (dwell_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OFF;
      pend_addr_q <= '0;
      um_addr_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pend_addr_q <= sel.req_addr;
      end
      // Address moves only while fully disabled, on the edge leaving DISABLE.
      if (state_q == DISABLE && dwell_last) begin
        um_addr_q <= pend_addr_q;
      end
      done_q <= (state_d == RUN) && (state_q != RUN);
    end
  end

  always_comb begin
    state_d    = state_q;
    dwell_load = 1'b0;
    dwell_val  = '0;
    case (state_q)
      OFF: begin
        if (accept) begin
          state_d    = DISABLE;
          dwell_load = 1'b1;
          dwell_val  = CNT_W'(SETTLE_CYCLES);
        end
      end
      RUN: begin
        if (accept) begin
          state_d = STOP_CLK;
        end
      end
      STOP_CLK: state_d = ASSERT_RST;
      ASSERT_RST: begin
        state_d    = DISABLE;
        dwell_load = 1'b1;
        dwell_val  = CNT_W'(SETTLE_CYCLES);
      end
      DISABLE: begin
        if (dwell_last) begin
          if (pend_addr_q == NONE_ADDR) begin
            state_d = OFF;
          end else begin
            state_d    = RESET_HOLD;
            dwell_load = 1'b1;
            dwell_val  = CNT_W'(RST_CYCLES);
          end
        end
      end
      RESET_HOLD: begin
        if (dwell_last) begin
          state_d = RUN;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Output decode of the state register: (ena, ui_pass, clk_en, rst_n).
  always_comb begin
    ena    = 1'b0;
    pass   = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    case (state_q)
      RUN:        {ena, pass, clk_en, rst_n} = 4'b1111;
      STOP_CLK:   {ena, pass, clk_en, rst_n} = 4'b1101;
      ASSERT_RST: {ena, pass, clk_en, rst_n} = 4'b1000;
      RESET_HOLD: {ena, pass, clk_en, rst_n} = 4'b1110;
      default:    {ena, pass, clk_en, rst_n} = 4'b0000;
    endcase
  end

  assign sel.req_ready = !busy;
  assign sel.busy      = busy;
  assign sel.done      = done_q;
  assign sel.um_addr   = um_addr_q;
  assign sel.um_ena    = ena;
  assign sel.ui_pass   = pass;
  assign sel.um_clk_en = clk_en;
  assign sel.um_rst_n  = rst_n;
endmodule

// File: tb/tb_tt_sel_sequencer.sv
// Directed bench for tt_sel_sequencer: switch sequences, NONE handling,
// held requests while busy, asynchronous reset and the ena-low invariant.
module tb_tt_sel_sequencer;
  import tt_sel_pkg::*;

  localparam int         AW   = 10;
  localparam logic [9:0] NONE = 10'h3FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_sel_sequencer_if #(.ADDR_W(AW)) bus ();

  tt_sel_sequencer #(
    .ADDR_W       (AW),
    .SETTLE_CYCLES(2),
    .RST_CYCLES   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  logic [9:0] prev_addr;
  logic       prev_ena;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bus.um_ena, bus.ui_pass, bus.um_clk_en, bus.um_rst_n};
  endfunction

  // Advance one clock; sample 1 time unit after the edge and check invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_ena_low", 32'(!bus.um_ena && (bus.ui_pass || bus.um_clk_en || bus.um_rst_n)), 0);
    chk("inv_addr_move", 32'((bus.um_addr != prev_addr) && prev_ena), 0);
    prev_addr = bus.um_addr;
    prev_ena  = bus.um_ena;
  endtask

  task automatic exp_state(input string tag, input logic [3:0] o, input logic [9:0] a,
                           input logic rdy, input logic dn);
    chk({tag, ".outs"},  32'(outs()), 32'(o));
    chk({tag, ".addr"},  32'(bus.um_addr), 32'(a));
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, ".busy"},  32'(bus.busy), 32'(!rdy));
    chk({tag, ".done"},  32'(bus.done), 32'(dn));
  endtask

  task automatic from_off(input string tag, input logic [9:0] old_a, input logic [9:0] new_a);
    bus.req_valid = 1'b1;
    bus.req_addr  = new_a;
    tick();
    exp_state({tag, ".dis0"}, 4'b0000, old_a, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    exp_state({tag, ".dis1"}, 4'b0000, old_a, 1'b0, 1'b0);
    tick();
    if (new_a == NONE) begin
      exp_state({tag, ".off"}, 4'b0000, NONE, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        exp_state({tag, ".hold"}, 4'b1110, new_a, 1'b0, 1'b0);
      end
      tick();
      exp_state({tag, ".run"}, 4'b1111, new_a, 1'b1, 1'b1);
    end
    $display("switch %s: OFF -> 0x%0h", tag, new_a);
  endtask

  // From RUN; with hold set, req_valid stays high and req_addr keeps changing while busy.
  task automatic switch_run(input string tag, input logic [9:0] old_a, input logic [9:0] new_a,
                            input logic hold);
    bus.req_valid = 1'b1;
    bus.req_addr  = new_a;
    tick();
    exp_state({tag, ".stop"}, 4'b1101, old_a, 1'b0, 1'b0);
    if (hold) bus.req_addr = new_a ^ 10'h155;
    else      bus.req_valid = 1'b0;
    tick();
    exp_state({tag, ".arst"}, 4'b1000, old_a, 1'b0, 1'b0);
    if (hold) bus.req_addr = new_a ^ 10'h0AA;
    tick();
    exp_state({tag, ".dis0"}, 4'b0000, old_a, 1'b0, 1'b0);
    if (hold) bus.req_addr = new_a ^ 10'h0F0;
    tick();
    exp_state({tag, ".dis1"}, 4'b0000, old_a, 1'b0, 1'b0);
    tick();
    if (new_a == NONE) begin
      exp_state({tag, ".off"}, 4'b0000, NONE, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        if (hold) bus.req_addr = new_a ^ 10'(i + 3);
        exp_state({tag, ".hold"}, 4'b1110, new_a, 1'b0, 1'b0);
      end
      tick();
      exp_state({tag, ".run"}, 4'b1111, new_a, 1'b1, 1'b1);
    end
    $display("switch %s: 0x%0h -> 0x%0h", tag, old_a, new_a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    #1;
    exp_state("reset", 4'b0000, 10'h000, 1'b1, 1'b0);
    prev_addr = '0;
    prev_ena  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    exp_state("idle", 4'b0000, 10'h000, 1'b1, 1'b0);

    from_off("off_to_5", 10'h000, 10'h005);
    switch_run("5_to_12_held", 10'h005, 10'h00C, 1'b1);
    switch_run("12_to_21", 10'h00C, 10'h021, 1'b0);
    switch_run("rereset_21", 10'h021, 10'h021, 1'b0);
    switch_run("21_to_none", 10'h021, NONE, 1'b0);
    from_off("none_from_off", NONE, NONE);

    // Asynchronous reset in the middle of RESET_HOLD.
    bus.req_valid = 1'b1;
    bus.req_addr  = 10'h007;
    tick();
    exp_state("pre_rst.dis0", 4'b0000, NONE, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    tick();
    exp_state("pre_rst.hold", 4'b1110, 10'h007, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    exp_state("async_rst", 4'b0000, 10'h000, 1'b1, 1'b0);
    $display("async reset during RESET_HOLD on 0x007");
    prev_addr = '0;
    prev_ena  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    exp_state("after_rst", 4'b0000, 10'h000, 1'b1, 1'b0);
    from_off("post_rst_3", 10'h000, 10'h003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_sel_sequencer.md
# tt_sel_sequencer

Sequencer that moves the multiplexer's active-design selection from one user design to another. It drives the selected address, `ena`, the user reset, the user clock enable and the input pass gate in a fixed safe order. The ordering guarantees the connectivity invariant: whenever `ena` is low, the user design sees clock low, reset asserted (`rst_n` = 0) and all-zero inputs. It sits between the chip controller (the requester) and the address decoder / mux spine.

## Interface
- `ADDR_W`, 10: width of the design address; the all-ones address is NONE (no design selected).
- `SETTLE_CYCLES`, 2: cycles spent fully disabled before the address changes; must be ≥ 1.
- `RST_CYCLES`, 4: clocked reset cycles applied to a newly selected design; must be ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  requester has a new target address.
- `req_addr`  in  ADDR_W  target address; NONE means deselect.
- `req_ready`  out  1  sequencer can accept a request.
- `busy`  out  1  a switch sequence is in progress.
- `done`  out  1  one-cycle pulse on entry to RUN.
- `um_addr`  out  ADDR_W  address driven to the decoder.
- `um_ena`  out  1  enable of the selected design.
- `um_rst_n`  out  1  user reset, active-low.
- `um_clk_en`  out  1  gates `clk` through to the user design.
- `ui_pass`  out  1  1 = pass `ui_in`; 0 = force user inputs to zero.

## Operation
- Handshake:
  - A request is accepted on a rising edge when `req_valid` and `req_ready` are both high.
  - `req_addr` is captured into `pend_addr` on that edge.
  - `req_ready` = !`busy`, high only in OFF and RUN.
  - While `busy`, `req_valid` is ignored; the requester holds it.
- Moore FSM. Outputs are a registered decode of the state, listed as (ena, ui_pass, clk_en, rst_n):
  - OFF (0,0,0,0): reset state. An accepted request goes to DISABLE.
  - RUN (1,1,1,1): design operating. An accepted request goes to STOP_CLK.
  - STOP_CLK (1,1,0,1): 1 cycle, then ASSERT_RST.
  - ASSERT_RST (1,0,0,0): 1 cycle, then DISABLE.
  - DISABLE (0,0,0,0): lasts SETTLE_CYCLES cycles.
    - On exit, `um_addr` ← `pend_addr`.
    - If `pend_addr` is NONE, go to OFF; otherwise go to RESET_HOLD.
  - RESET_HOLD (1,1,1,0): lasts RST_CYCLES cycles with the clock running, then RUN. `done` is asserted for the first cycle in RUN.
- Power-down order is clock off, then reset asserted and inputs gated, then `ena` low.
- Power-up order is `ena`, inputs and clock on together with reset held, then reset released.
- `um_addr` changes only on the edge leaving DISABLE, so it is never changed while `um_ena` = 1.
- Dwell counter:
  - Width is `$clog2(max(SETTLE_CYCLES,RST_CYCLES)+1)`.
  - It is loaded on entry to DISABLE or RESET_HOLD and decremented each cycle; the state is left when the count reaches 1.
- Boundary cases:
  - Request for the address already selected: the full sequence still runs. This is the re-reset path.
  - NONE requested from OFF: the sequence is OFF → DISABLE → OFF, `um_addr` is set to NONE, and there is no `done`.
  - A request arriving in the same cycle as `done`: accepted, since `req_ready` is high in RUN.
  - `rst` asserted mid-sequence: immediately (asynchronously) go to OFF with all outputs 0, `um_addr` = 0 and `pend_addr` = 0.

## Timing
- Reset values:
  - `um_addr` = 0.
  - `um_ena`, `um_rst_n`, `um_clk_en`, `ui_pass`, `busy`, `done` = 0.
  - `req_ready` = 1.
- Switch latency, counted from the accepting edge in RUN to the first cycle of RUN for the new design: 2 + SETTLE_CYCLES + RST_CYCLES cycles, which is 8 at the defaults.
- Latency from OFF: SETTLE_CYCLES + RST_CYCLES cycles, which is 6 at the defaults.
- Every output is a flop or a decode of the state flops; there is no combinational path from request input to output except `req_ready` = f(state).

## Structure
- Package `tt_sel_pkg`:
  - state enum `sel_state_t` (OFF, STOP_CLK, ASSERT_RST, DISABLE, RESET_HOLD, RUN);
  - function returning NONE for a given `ADDR_W`;
  - default cycle constants.
- Optional sub-module `tt_sel_dwell`: loadable down-counter with a `last` flag, shared by DISABLE and RESET_HOLD. Everything else stays in the top module.

## Test plan
- Reset, then request addr 5 from OFF:
  - `req_ready` drops the next cycle.
  - 2 cycles of all-zero outputs, then `um_addr` = 5 with (1,1,1,0) for 4 cycles.
  - Then RUN (1,1,1,1) with `done` high for 1 cycle.
- In RUN on addr 5, request addr 12:
  - Exact sequence STOP_CLK, ASSERT_RST, DISABLE×2, RESET_HOLD×4, RUN; `done` 8 cycles after acceptance.
  - `um_addr` stays 5 until DISABLE exits.
- Request NONE (0x3FF) from RUN: ends in OFF with `um_addr` = 0x3FF, all enables 0, no `done`.
- Hold `req_valid` high with a changing `req_addr` while busy: ignored. The next request is accepted only in RUN, and `pend_addr` equals the value present on that edge.
- Assert `rst` during RESET_HOLD: all outputs 0 in the same cycle with no clock edge needed; after release, state is OFF with `req_ready` = 1.
- Property check on every cycle: `um_ena` = 0 implies `um_clk_en` = 0, `um_rst_n` = 0 and `ui_pass` = 0; `um_addr` changes only when `um_ena` = 0.
